regfile_wb_queue: RTL and testbench

Write-back queue in front of the 32x32 register file. It accepts destination/data results from two producers: port A, the single-cycle ALU path, and port B, the load / multi-cycle path. It buffers them in an in-order FIFO and drains exactly one register-file write per cycle on the register file's write interface (`RegWrite`, `RegDst`, `rc`, `wdata`). It also snoops the register file's read addresses and provides forwarding data and a pending-write scoreboard for results that have not yet committed.

---
 rtl/regfile_wb_queue_if.sv | 38 +++
 rtl/regfile_wb_queue.sv | 134 +++++++++++++
 tb/tb_regfile_wb_queue.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_queue_if.sv
// Bundle between the write-back queue, its producers, and the register file.
interface regfile_wb_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
);
  logic          a_valid;
  logic          a_ready;
  logic [4:0]    a_dst;
  logic [31:0]   a_data;
  logic          b_valid;
  logic          b_ready;
  logic [4:0]    b_dst;
  logic [31:0]   b_data;
  logic          RegWrite;
  logic [1:0]    RegDst;
  logic [4:0]    rc;
  logic [31:0]   wdata;
  logic [4:0]    ra;
  logic [4:0]    rb;
  logic          fwd_a_hit;
  logic          fwd_b_hit;
  logic [31:0]   fwd_a_data;
  logic [31:0]   fwd_b_data;
  logic [31:0]   pending;
  logic [CW-1:0] count;

  modport slave (
    input  a_valid, a_dst, a_data, b_valid, b_dst, b_data, ra, rb,
    output a_ready, b_ready, RegWrite, RegDst, rc, wdata,
           fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data, pending, count
  );

  modport master (
    output a_valid, a_dst, a_data, b_valid, b_dst, b_data, ra, rb,
    input  a_ready, b_ready, RegWrite, RegDst, rc, wdata,
           fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data, pending, count
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order write-back FIFO with one write per cycle, forwarding and pending scoreboard.
module regfile_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input logic           clk,
  input logic           rst_n,
  regfile_wb_queue_if.slave bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;

  logic [RW-1:0] dst_q  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wb_valid_q, wb_valid_d;
  logic [RW-1:0] rc_q, rc_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          a_ready_c, b_ready_c;
  logic          push_a_c, push_b_c, pop_c;
  logic [PW-1:0] wr_ptr_a_c;
  logic [PW-1:0] fwd_idx;
  logic          fwd_a_hit_c, fwd_b_hit_c;
  logic [DW-1:0] fwd_a_data_c, fwd_b_data_c;
  logic [31:0]   pending_c;

  // Acceptance: B gets priority on the last free slot; the same-cycle pop is not credited.
  assign b_ready_c  = (count_q <= CW'(DEPTH - 1));
  assign a_ready_c  = bus.b_valid ? (count_q <= CW'(DEPTH - 2)) : b_ready_c;
  assign push_b_c   = bus.b_valid & b_ready_c & (bus.b_dst != '0);
  assign push_a_c   = bus.a_valid & a_ready_c & (bus.a_dst != '0);
  assign pop_c      = (count_q != '0);
  assign wr_ptr_a_c = wr_ptr_q + PW'(push_b_c);

  // Next-state for pointers, occupancy and the output stage.
  always_comb begin
    rd_ptr_d   = rd_ptr_q + PW'(pop_c);
    wr_ptr_d   = wr_ptr_q + PW'(push_a_c) + PW'(push_b_c);
    count_d    = count_q + CW'(push_a_c) + CW'(push_b_c) - CW'(pop_c);
    wb_valid_d = 1'b0;
    rc_d       = '0;
    wdata_d    = '0;
    if (pop_c) begin
      wb_valid_d = 1'b1;
      rc_d       = dst_q[rd_ptr_q];
      wdata_d    = data_q[rd_ptr_q];
    end
  end

  // Control state; reset drops RegWrite immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wb_valid_q <= 1'b0;
      rc_q       <= '0;
      wdata_q    <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wb_valid_q <= wb_valid_d;
      rc_q       <= rc_d;
      wdata_q    <= wdata_d;
    end
  end

  // Entry storage; B lands first so A is the younger of a same-cycle pair.
  always_ff @(posedge clk) begin
    if (push_b_c) begin
      dst_q[wr_ptr_q]  <= bus.b_dst;
      data_q[wr_ptr_q] <= bus.b_data;
    end
    if (push_a_c) begin
      dst_q[wr_ptr_a_c]  <= bus.a_dst;
      data_q[wr_ptr_a_c] <= bus.a_data;
    end
  end

  // Forwarding and pending: output stage is oldest, later FIFO offsets override earlier ones.
  always_comb begin
    fwd_a_hit_c  = 1'b0;
    fwd_b_hit_c  = 1'b0;
    fwd_a_data_c = '0;
    fwd_b_data_c = '0;
    pending_c    = '0;
    fwd_idx      = '0;
    if (wb_valid_q) begin
      pending_c[rc_q] = 1'b1;
      if ((bus.ra != '0) && (bus.ra == rc_q)) begin
        fwd_a_hit_c  = 1'b1;
        fwd_a_data_c = wdata_q;
      end
      if ((bus.rb != '0) && (bus.rb == rc_q)) begin
        fwd_b_hit_c  = 1'b1;
        fwd_b_data_c = wdata_q;
      end
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        pending_c[dst_q[fwd_idx]] = 1'b1;
        if ((bus.ra != '0) && (bus.ra == dst_q[fwd_idx])) begin
          fwd_a_hit_c  = 1'b1;
          fwd_a_data_c = data_q[fwd_idx];
        end
        if ((bus.rb != '0) && (bus.rb == dst_q[fwd_idx])) begin
          fwd_b_hit_c  = 1'b1;
          fwd_b_data_c = data_q[fwd_idx];
        end
      end
    end
    pending_c[0] = 1'b0;
  end

  assign bus.a_ready    = a_ready_c;
  assign bus.b_ready    = b_ready_c;
  assign bus.RegWrite   = wb_valid_q;
  assign bus.RegDst     = 2'b00;
  assign bus.rc         = rc_q;
  assign bus.wdata      = wdata_q;
  assign bus.count      = count_q;
  assign bus.pending    = pending_c;
  assign bus.fwd_a_hit  = fwd_a_hit_c;
  assign bus.fwd_b_hit  = fwd_b_hit_c;
  assign bus.fwd_a_data = fwd_a_data_c;
  assign bus.fwd_b_data = fwd_b_data_c;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Randomized bench with a queue-based reference model and a write-port scoreboard.
module tb_regfile_wb_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  bit   mon_en;

  ent_t fifo_m[$];
  ent_t exp_q[$];
  ent_t infl_m;
  bit   infl_v;

  regfile_wb_queue_if #(.DEPTH(DEPTH), .CW(CW)) bus ();

  regfile_wb_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Youngest pending value for register r: FIFO tail first, then the in-flight write.
  function automatic logic [32:0] fwd_model(input logic [4:0] r);
    if (r == 5'd0) return 33'd0;
    for (int i = fifo_m.size() - 1; i >= 0; i--)
      if (fifo_m[i].dst == r) return {1'b1, fifo_m[i].data};
    if (infl_v && infl_m.dst == r) return {1'b1, infl_m.data};
    return 33'd0;
  endfunction

  function automatic logic [31:0] pend_model();
    logic [31:0] p;
    p = '0;
    foreach (fifo_m[i]) p[fifo_m[i].dst] = 1'b1;
    if (infl_v) p[infl_m.dst] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // One clock of stimulus: drive, check combinational outputs, then advance the model.
  task automatic cycle(input bit av, input logic [4:0] ad, input logic [31:0] adata,
                       input bit bv, input logic [4:0] bd, input logic [31:0] bdata,
                       input logic [4:0] r_a, input logic [4:0] r_b);
    bit acc_a, acc_b;
    logic [32:0] fa, fb;
    int sz;
    @(negedge clk);
    bus.a_valid = av; bus.a_dst = ad; bus.a_data = adata;
    bus.b_valid = bv; bus.b_dst = bd; bus.b_data = bdata;
    bus.ra = r_a; bus.rb = r_b;
    #1;
    sz    = fifo_m.size();
    acc_b = bv && (sz <= DEPTH - 1);
    acc_a = av && (bv ? (sz <= DEPTH - 2) : (sz <= DEPTH - 1));
    fa = fwd_model(r_a);
    fb = fwd_model(r_b);
    chk("b_ready", 32'(bus.b_ready), 32'(acc_b | ~bv & (sz <= DEPTH - 1)));
    if (av) chk("a_ready", 32'(bus.a_ready), 32'(acc_a));
    chk("count", 32'(bus.count), 32'(sz));
    chk("pending", bus.pending, pend_model());
    chk("fwd_a_hit", 32'(bus.fwd_a_hit), 32'(fa[32]));
    chk("fwd_a_data", bus.fwd_a_data, fa[31:0]);
    chk("fwd_b_hit", 32'(bus.fwd_b_hit), 32'(fb[32]));
    chk("fwd_b_data", bus.fwd_b_data, fb[31:0]);
    chk("RegDst", 32'(bus.RegDst), 32'd0);
    @(posedge clk);
    if (fifo_m.size() > 0) begin
      infl_m = fifo_m.pop_front();
      infl_v = 1'b1;
    end else begin
      infl_v = 1'b0;
    end
    if (acc_b && bd != 5'd0) begin
      fifo_m.push_back({bd, bdata});
      exp_q.push_back({bd, bdata});
    end
    if (acc_a && ad != 5'd0) begin
      fifo_m.push_back({ad, adata});
      exp_q.push_back({ad, adata});
    end
  endtask

  task automatic idle(input int n, input logic [4:0] r_a, input logic [4:0] r_b);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r_a, r_b);
  endtask

  // Monitor: every write presented to the register file must be the oldest expected one.
  initial begin
    ent_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && rst_n) begin
        if (bus.RegWrite) begin
          if (exp_q.size() == 0) begin
            chk("write_unexpected", 32'(bus.rc), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("wb_rc", 32'(bus.rc), 32'(e.dst));
            chk("wb_wdata", bus.wdata, e.data);
          end
        end else begin
          chk("idle_rc", 32'(bus.rc), 32'd0);
          chk("idle_wdata", bus.wdata, 32'd0);
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    mon_en   = 1'b0;
    infl_v   = 1'b0;
    rst_n    = 1'b0;
    bus.a_valid = 1'b0; bus.a_dst = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_dst = '0; bus.b_data = '0;
    bus.ra = '0; bus.rb = '0;
    #1;
    chk("rst_RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("rst_rc", 32'(bus.rc), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_pending", bus.pending, 32'd0);
    chk("rst_fwd_a_hit", 32'(bus.fwd_a_hit), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single A write, observed through forwarding until it commits.
    cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    idle(3, 5'd5, 5'd6);

    // Same-destination pair: B drains first, A's value stays forwarded.
    cycle(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 5'd7, 5'd7);
    idle(3, 5'd7, 5'd0);

    // r0 results complete the handshake but leave no trace.
    cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle(2, 5'd0, 5'd1);

    // Saturating fill with both ports, then drain and wrap.
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b1, 5'(i + 9), 32'h200 + 32'(i),
            5'(i + 1), 5'(i + 9));
    idle(6, 5'd3, 5'd10);

    // Randomized traffic with register collisions and r0 results.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    idle(6, 5'd1, 5'd2);

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 10 && fifo_m.size() != 3; i++)
      cycle(1'b1, 5'd20 + 5'(i), 32'hA0 + 32'(i), 1'b1, 5'd12, 32'hB0 + 32'(i), 5'd12, 5'd20);
    chk("pre_rst_count_model", 32'(fifo_m.size()), 32'd3);
    @(negedge clk);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("async_rc", 32'(bus.rc), 32'd0);
    chk("async_wdata", bus.wdata, 32'd0);
    chk("async_pending", bus.pending, 32'd0);
    chk("async_count", 32'(bus.count), 32'd0);
    fifo_m.delete();
    exp_q.delete();
    infl_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4, 5'd12, 5'd20);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
